// File: rtl/comp_mem_ctrl.sv
// Compensation weight memory sequencer: streams a full weight image into
// sequential write addresses, then serves column-group read requests.
module comp_mem_ctrl #(
  parameter int SIZE            = 8,
  parameter int NUM_COL         = 3,
  parameter int CMEM_SIZE       = SIZE * NUM_COL,
  parameter int CMEM_ADDR_WIDTH = $clog2(CMEM_SIZE)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_start,
  input  logic [3:0]                 cw_in,
  input  logic                       cw_valid,
  output logic                       cw_ready,
  input  logic                       rd_req,
  input  logic [1:0]                 rd_col,
  output logic                       rd_ready,
  output logic [3:0]                 Compensation_Weight,
  output logic [CMEM_ADDR_WIDTH-1:0] Wr_Addr,
  output logic                       Wr_en,
  output logic [1:0]                 Rd_Addr,
  output logic                       Rd_en,
  output logic                       cw_out_valid,
  output logic [1:0]                 cw_out_col,
  output logic                       loaded,
  output logic                       err
);

  // state | meaning
  // IDLE  | no image, waiting for load_start
  // LOAD  | accepting weight beats
  // LAST  | final write visible, image complete next cycle
  // READY | image resident, no read in flight
  // READ  | read issued last cycle
  typedef enum logic [2:0] {IDLE, LOAD, LAST, READY, READ} state_t;

  localparam logic [CMEM_ADDR_WIDTH-1:0] LAST_ADDR = CMEM_ADDR_WIDTH'(CMEM_SIZE - 1);
  localparam logic [2:0]                 NUM_COL_W = 3'(NUM_COL);

  state_t                     state, state_nxt;
  logic [CMEM_ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic [CMEM_ADDR_WIDTH-1:0] wr_addr_nxt;
  logic [3:0]                 wdata_nxt;
  logic [1:0]                 rd_addr_nxt;
  logic                       wr_en_nxt, rd_en_nxt, loaded_nxt, err_nxt;
  logic                       beat, col_ok, rd_ok;

  assign cw_ready = (state == LOAD);
  assign rd_ready = ((state == READY) || (state == READ)) && !load_start;
  assign beat     = cw_valid && cw_ready && !load_start;
  assign col_ok   = ({1'b0, rd_col} < NUM_COL_W);
  assign rd_ok    = rd_req && rd_ready && col_ok;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    loaded_nxt  = loaded;
    err_nxt     = err;
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = Wr_Addr;
    wdata_nxt   = Compensation_Weight;
    rd_en_nxt   = 1'b0;
    rd_addr_nxt = Rd_Addr;

    if (beat) begin
      wr_en_nxt   = 1'b1;
      wr_addr_nxt = cnt;
      wdata_nxt   = cw_in;
      cnt_nxt     = cnt + CMEM_ADDR_WIDTH'(1);
    end

    if (rd_ok) begin
      rd_en_nxt   = 1'b1;
      rd_addr_nxt = rd_col;
    end

    // Covers both a bad column and a request outside READY/READ.
    if (rd_req && !load_start && !rd_ok) err_nxt = 1'b1;

    case (state)
      IDLE:  state_nxt = IDLE;
      LOAD:  if (beat && (cnt == LAST_ADDR)) state_nxt = LAST;
      LAST: begin
        state_nxt  = READY;
        loaded_nxt = 1'b1;
      end
      READY, READ: state_nxt = rd_ok ? READ : READY;
      default: state_nxt = IDLE;
    endcase

    if (load_start) begin
      state_nxt  = LOAD;
      cnt_nxt    = '0;
      err_nxt    = 1'b0;
      loaded_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      cnt                 <= '0;
      loaded              <= 1'b0;
      err                 <= 1'b0;
      Wr_en               <= 1'b0;
      Wr_Addr             <= '0;
      Compensation_Weight <= '0;
      Rd_en               <= 1'b0;
      Rd_Addr             <= '0;
      cw_out_valid        <= 1'b0;
      cw_out_col          <= '0;
    end else begin
      state               <= state_nxt;
      cnt                 <= cnt_nxt;
      loaded              <= loaded_nxt;
      err                 <= err_nxt;
      Wr_en               <= wr_en_nxt;
      Wr_Addr             <= wr_addr_nxt;
      Compensation_Weight <= wdata_nxt;
      Rd_en               <= rd_en_nxt;
      Rd_Addr             <= rd_addr_nxt;
      // Memory output lags the read strobe by one cycle, even across a reload.
      cw_out_valid        <= Rd_en;
      cw_out_col          <= Rd_Addr;
    end
  end

endmodule

// File: doc/comp_mem_ctrl.md
Name: comp_mem_ctrl

Overview:
- Sequencer for the compensation weight memory (SIZE x 3 entries of 4-bit weights, 1-cycle registered read of one column-group per Rd_Addr).
- Loads a full weight image from a valid/ready stream into sequential addresses.
- Serves column-group read requests from the systolic-array pre-load unit.
- Flags the output word valid in the cycle the memory output updates.
- Guarantees Wr_en and Rd_en are never asserted together.

Parameters:
- SIZE, 8, systolic array dimension (rows per column-group).
- NUM_COL, 3, column-groups held in memory.
- CMEM_SIZE, SIZE*NUM_COL, memory depth.
- CMEM_ADDR_WIDTH, $clog2(CMEM_SIZE), write address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- load_start  in  1  pulse: begin (re)load of the full image.
- cw_in  in  4  incoming compensation weight.
- cw_valid  in  1  cw_in valid.
- cw_ready  out  1  controller accepts cw_in.
- rd_req  in  1  read request for one column-group.
- rd_col  in  2  requested column-group index.
- rd_ready  out  1  rd_req will be accepted this cycle.
- Compensation_Weight  out  4  write data to memory.
- Wr_Addr  out  CMEM_ADDR_WIDTH  write address.
- Wr_en  out  1  memory write strobe.
- Rd_Addr  out  2  memory read column-group.
- Rd_en  out  1  memory read strobe.
- cw_out_valid  out  1  memory output word is fresh this cycle.
- cw_out_col  out  2  column-group of the fresh word.
- loaded  out  1  full image resident.
- err  out  1  sticky protocol error.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: all outputs 0, including cw_ready, rd_ready and err. State IDLE. Write counter 0.
- Reset mid-load or mid-read aborts immediately. The partial image is discarded: loaded=0.
- States: IDLE, LOAD, LAST, READY, READ.
- cw_ready = (state==LOAD).
- rd_ready = (state==READY or READ) and not load_start.
- IDLE: load_start -> LOAD, counter cleared, err cleared.
- LOAD:
  - A beat is accepted when cw_valid&&cw_ready at cycle T.
  - At T+1: Wr_en=1, Wr_Addr=counter, Compensation_Weight=cw_in from T. The counter then increments.
  - Address order is strictly sequential, 0..CMEM_SIZE-1. Entry r*NUM_COL+c holds row r, column-group c.
  - If cw_valid is low, the cycle produces no write (Wr_en=0). Bubbles are legal.
  - The beat with counter==CMEM_SIZE-1 moves the state to LAST.
- LAST:
  - One cycle. The final Wr_en is visible in this cycle. cw_ready=0.
  - Next state READY, with loaded=1 from the following cycle.
- READY and READ, read handshake:
  - Request accepted at T when rd_req && rd_ready && rd_col<NUM_COL.
  - T+1: Rd_en=1, Rd_Addr=rd_col, state READ.
  - T+2: cw_out_valid=1, cw_out_col=rd_col. This is a 2-cycle request-to-data latency.
  - Back-to-back requests in READ are accepted: one read per cycle sustained.
  - READ with no new request returns to READY. Rd_en=0 and Rd_Addr holds its last value.
- Invalid requests:
  - rd_col>=NUM_COL: no read is issued, err=1.
  - rd_req while not rd_ready (IDLE, LOAD, LAST): ignored, err=1.
- load_start during LOAD/LAST:
  - Restarts the load. Counter=0, loaded stays 0.
  - Any beat offered in that cycle is not accepted.
- load_start in READY/READ:
  - Has priority over a simultaneous rd_req, which is dropped without setting err.
  - loaded falls to 0 next cycle, state LOAD.
  - A read issued in the previous cycle still completes: cw_out_valid fires at its T+2.
- Exclusivity: Wr_en and Rd_en are never both 1. This holds by construction, since reads occur only in READY/READ.
- err clears only on rst or load_start.
- All outputs are registered. No combinational path from input to output except cw_ready/rd_ready, which depend on state and load_start.

Test Plan:
- Reset, then load_start, then 24 beats cw_in=k[3:0] (k=0..23) with cw_valid held high -> Wr_en for 24 consecutive cycles. Wr_Addr 0..23 and Compensation_Weight=k. loaded=1 two cycles after the last beat.
- Same load with cw_valid toggling every other cycle -> exactly 24 writes, addresses contiguous, no write in bubble cycles.
- After load, rd_req with rd_col=0,1,2 on consecutive cycles -> Rd_en high 3 cycles with Rd_Addr 0,1,2. cw_out_valid high 3 cycles with cw_out_col 0,1,2, each 2 cycles after its request.
- rd_col=3 in READY -> no Rd_en, err=1. rd_req in LOAD -> ignored, err=1. Next load_start clears err.
- load_start and rd_req together in READY -> no Rd_en, loaded=0 next cycle, cw_ready=1, err stays 0.
- rst asserted after 10 beats of a load -> all outputs 0. A following load_start restarts at Wr_Addr=0.
